// File: rtl/checker_pkg.sv
// Shared definitions for the checker stream arbiter: FSM encoding, framing
// characters and format-result codes.
package checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   localparam logic [7:0] CH_START = 8'h5E;  // '^'
   localparam logic [7:0] CH_END   = 8'h23;  // '#'
   localparam logic [7:0] CH_NUL   = 8'h00;

   localparam logic [1:0] FMT_INVALID = 2'd0;
   localparam logic [1:0] FMT_TYPE_A  = 2'd1;
   localparam logic [1:0] FMT_TYPE_B  = 2'd2;
   localparam logic [1:0] FMT_TYPE_C  = 2'd3;

   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/stream_watchdog.sv
// Saturating-free event counter with terminal-count detect; used both for
// consecutive stall cycles and for record length.
module stream_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic clear,
   output logic expired
);

   localparam int             W  = $clog2(LIMIT + 1);
   localparam logic [W-1:0]   TC = W'(LIMIT - 1);

   logic [W-1:0] count;

   // clear together with tick restarts the count at one (the ticking event itself)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= tick ? W'(1) : '0;
      else if (tick)
         count <= count + W'(1);
   end

   assign expired = tick && !clear && (count == TC);

endmodule

// File: rtl/checker_stream_arbiter.sv
// Two-requester arbiter feeding one shared format checker with framed
// '^' ... '#' records, reporting one result per record.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | both ready, non-'^' discarded, waiting for a record start
// STREAM  | owner locked, characters forwarded one cycle late
// FLUSH   | '#' on chk_char, nobody ready
// CAPTURE | checker result valid on fmt_type, latched at end of cycle
module checker_stream_arbiter
   import checker_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int MAX_LEN = 48
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_char,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_char,
   output logic       req1_ready,
   output logic [7:0] chk_char,
   input  logic [1:0] fmt_type,
   output logic       res_valid,
   output logic       res_id,
   output logic [1:0] res_type,
   output logic [1:0] grant
);

   state_t     state;
   logic       owner;
   logic       prio;

   logic       idle;
   logic       streaming;
   logic       start0;
   logic       start1;
   logic       both_start;
   logic       start_acc;
   logic       start_id;
   logic       own_valid;
   logic [7:0] own_char;
   logic       own_acc;

   logic       len_tick;
   logic       len_clear;
   logic       len_exp;
   logic       stall_tick;
   logic       stall_clear;
   logic       stall_exp;

   always_comb begin
      idle       = (state == ST_IDLE);
      streaming  = (state == ST_STREAM);
      start0     = req0_valid && (req0_char == CH_START);
      start1     = req1_valid && (req1_char == CH_START);
      both_start = start0 && start1;
      start_acc  = idle && (start0 || start1);
      start_id   = both_start ? prio : start1;
      own_valid  = owner ? req1_valid : req0_valid;
      own_char   = owner ? req1_char : req0_char;
      own_acc    = streaming && own_valid;

      // only a tie on '^' holds off the non-priority requester while idle
      req0_ready = idle ? !(both_start && prio)  : (streaming && !owner);
      req1_ready = idle ? !(both_start && !prio) : (streaming && owner);

      len_tick    = start_acc || own_acc;
      len_clear   = !streaming || (own_acc && (own_char == CH_START));
      stall_tick  = streaming && !own_valid;
      stall_clear = !streaming || own_valid;
   end

   assign grant = idle ? 2'b00 : owner_onehot(owner);

   stream_watchdog #(.LIMIT(MAX_LEN)) u_len_wd (
      .clk     (clk),
      .reset   (reset),
      .tick    (len_tick),
      .clear   (len_clear),
      .expired (len_exp)
   );

   stream_watchdog #(.LIMIT(TIMEOUT)) u_stall_wd (
      .clk     (clk),
      .reset   (reset),
      .tick    (stall_tick),
      .clear   (stall_clear),
      .expired (stall_exp)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         owner     <= 1'b0;
         prio      <= 1'b0;
         chk_char  <= CH_NUL;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         res_type  <= FMT_INVALID;
      end else begin
         res_valid <= 1'b0;
         chk_char  <= CH_NUL;
         case (state)
            ST_IDLE: begin
               if (start_acc) begin
                  owner    <= start_id;
                  chk_char <= CH_START;
                  state    <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (own_acc && (own_char == CH_END)) begin
                  chk_char <= CH_END;
                  state    <= ST_FLUSH;
               end else if ((own_acc && len_exp) || stall_exp) begin
                  // aborted record: the truncating character is not forwarded
                  res_valid <= 1'b1;
                  res_id    <= owner;
                  res_type  <= FMT_INVALID;
                  prio      <= ~owner;
                  state     <= ST_IDLE;
               end else if (own_acc) begin
                  chk_char <= own_char;
               end
            end
            ST_FLUSH: begin
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               res_valid <= 1'b1;
               res_id    <= owner;
               res_type  <= fmt_type;
               prio      <= ~owner;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_checker_stream_arbiter.sv
// Self-checking bench for checker_stream_arbiter: reset-time table, directed
// record sequences and a randomized run against a record-level model.
module tb_checker_stream_arbiter;

   localparam int TO = 16;
   localparam int ML = 48;
   localparam logic [7:0] K_START = 8'h5E;
   localparam logic [7:0] K_END   = 8'h23;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_char = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_char = 8'h00;
   logic       req1_ready;
   logic [7:0] chk_char;
   logic [1:0] fmt_type = 2'd0;
   logic       res_valid;
   logic       res_id;
   logic [1:0] res_type;
   logic [1:0] grant;

   always #5 clk = ~clk;

   checker_stream_arbiter #(.TIMEOUT(TO), .MAX_LEN(ML)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_char  (req0_char),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_char  (req1_char),
      .req1_ready (req1_ready),
      .chk_char   (chk_char),
      .fmt_type   (fmt_type),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_type   (res_type),
      .grant      (grant)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // record-level reference: busy/owner plus cycles elapsed since '#'
   bit         m_busy;
   int         m_own, m_prio, m_len, m_stall, m_end;
   int         e_chk, e_rid, e_rtype;
   bit         e_rv;

   int s_rdy0, s_rdy1, s_rv, s_rid, s_rtype, s_grant, s_chk;

   task automatic model_reset();
      m_busy = 0; m_own = 0; m_prio = 0; m_len = 0; m_stall = 0; m_end = 0;
      e_chk = 0; e_rv = 0; e_rid = 0; e_rtype = 0;
   endtask

   task automatic model_ready(input bit v0, input logic [7:0] c0, input bit v1,
                              input logic [7:0] c1, output bit r0, output bit r1);
      bit s0, s1;
      s0 = v0 && (c0 == K_START);
      s1 = v1 && (c1 == K_START);
      if (!m_busy) begin
         r0 = !(s0 && s1 && m_prio == 1);
         r1 = !(s0 && s1 && m_prio == 0);
      end else if (m_end == 0) begin
         r0 = (m_own == 0);
         r1 = (m_own == 1);
      end else begin
         r0 = 0;
         r1 = 0;
      end
   endtask

   task automatic report(input int t);
      e_rv = 1; e_rid = m_own; e_rtype = t;
      m_prio = 1 - m_own; m_busy = 0; m_end = 0;
   endtask

   task automatic model_step(input bit v0, input logic [7:0] c0, input bit v1,
                             input logic [7:0] c1, input logic [1:0] fmt);
      bit s0, s1, ov;
      logic [7:0] oc;
      e_rv = 0;
      e_chk = 0;
      if (!m_busy) begin
         s0 = v0 && (c0 == K_START);
         s1 = v1 && (c1 == K_START);
         if (s0 || s1) begin
            m_own = (s0 && s1) ? m_prio : (s1 ? 1 : 0);
            m_busy = 1; m_len = 1; m_stall = 0; m_end = 0;
            e_chk = int'(K_START);
         end
      end else if (m_end == 1) begin
         m_end = 2;
      end else if (m_end == 2) begin
         report(int'(fmt));
      end else begin
         ov = (m_own == 1) ? v1 : v0;
         oc = (m_own == 1) ? c1 : c0;
         if (ov) begin
            m_stall = 0;
            if (oc == K_END) begin
               m_end = 1;
               e_chk = int'(K_END);
            end else if (oc == K_START) begin
               m_len = 1;
               e_chk = int'(K_START);
            end else begin
               m_len++;
               if (m_len >= ML) report(0);
               else e_chk = int'(oc);
            end
         end else begin
            m_stall++;
            if (m_stall >= TO) report(0);
         end
      end
   endtask

   task automatic step_cycle(input bit v0, input logic [7:0] c0, input bit v1,
                             input logic [7:0] c1, input logic [1:0] fmt);
      bit er0, er1;
      req0_valid = v0; req0_char = c0;
      req1_valid = v1; req1_char = c1;
      fmt_type = fmt;
      @(negedge clk);
      model_ready(v0, c0, v1, c1, er0, er1);
      check("ready0", int'(req0_ready), int'(er0));
      check("ready1", int'(req1_ready), int'(er1));
      check("chk_char", int'(chk_char), e_chk);
      check("res_valid", int'(res_valid), int'(e_rv));
      check("grant", int'(grant), m_busy ? ((m_own == 1) ? 2 : 1) : 0);
      if (e_rv) begin
         check("res_id", int'(res_id), e_rid);
         check("res_type", int'(res_type), e_rtype);
      end
      s_rdy0 = int'(req0_ready); s_rdy1 = int'(req1_ready);
      s_rv = int'(res_valid); s_rid = int'(res_id); s_rtype = int'(res_type);
      s_grant = int'(grant); s_chk = int'(chk_char);
      model_step(v0, c0, v1, c1, fmt);
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input bit who, input string s, input logic [1:0] fmt);
      for (int i = 0; i < s.len(); i++) begin
         if (who) step_cycle(1'b0, 8'h00, 1'b1, s[i], fmt);
         else     step_cycle(1'b1, s[i], 1'b0, 8'h00, fmt);
      end
   endtask

   task automatic idle_cycles(input int n, input logic [1:0] fmt);
      for (int i = 0; i < n; i++) step_cycle(1'b0, 8'h00, 1'b0, 8'h00, fmt);
   endtask

   function automatic logic [7:0] rand_char();
      int r;
      r = $urandom_range(0, 19);
      if (r < 3) return K_START;
      if (r < 5) return K_END;
      return 8'h61 + 8'(r);
   endfunction

   typedef struct {
      bit         v0;
      logic [7:0] c0;
      bit         v1;
      logic [7:0] c1;
      bit         r0;
      bit         r1;
   } vec_t;

   vec_t tbl[6];
   int   lat;
   int   hit_type, hit_grant;

   initial begin
      model_reset();
      tbl[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[1] = '{1'b1, "a",   1'b1, "b",   1'b1, 1'b1};
      tbl[2] = '{1'b1, "^",   1'b0, 8'h00, 1'b1, 1'b1};
      tbl[3] = '{1'b1, "^",   1'b1, "^",   1'b1, 1'b0};
      tbl[4] = '{1'b1, "a",   1'b1, "^",   1'b1, 1'b1};
      tbl[5] = '{1'b0, "^",   1'b1, "^",   1'b1, 1'b1};

      // held in reset: idle ready rules with priority at its reset value
      #1;
      for (int i = 0; i < 6; i++) begin
         req0_valid = tbl[i].v0; req0_char = tbl[i].c0;
         req1_valid = tbl[i].v1; req1_char = tbl[i].c1;
         #2;
         check($sformatf("tbl%0d_ready0", i), int'(req0_ready), int'(tbl[i].r0));
         check($sformatf("tbl%0d_ready1", i), int'(req1_ready), int'(tbl[i].r1));
         check($sformatf("tbl%0d_chk", i), int'(chk_char), 0);
         check($sformatf("tbl%0d_grant", i), int'(grant), 0);
         check($sformatf("tbl%0d_resv", i), int'(res_valid), 0);
      end
      req0_valid = 0; req1_valid = 0;
      @(posedge clk); #1;
      reset = 1'b1;

      // simultaneous starts: req0 first, req1 next, then req0 again
      step_cycle(1, "^", 1, "^", 2'd1);
      check("r031_loser_ready", s_rdy1, 0);
      check("r031_winner_ready", s_rdy0, 1);
      step_cycle(1, "a", 1, "^", 2'd1);
      check("r031_grant_req0", s_grant, 1);
      step_cycle(1, "#", 1, "^", 2'd1);
      step_cycle(0, 8'h00, 1, "^", 2'd1);
      step_cycle(0, 8'h00, 1, "^", 2'd1);
      step_cycle(0, 8'h00, 1, "^", 2'd1);
      check("r031_res0_valid", s_rv, 1);
      check("r031_res0_id", s_rid, 0);
      step_cycle(0, 8'h00, 1, "c", 2'd1);
      check("r031_grant_req1", s_grant, 2);
      step_cycle(0, 8'h00, 1, "#", 2'd1);
      idle_cycles(3, 2'd1);
      check("r031_res1_id", s_rid, 1);
      step_cycle(1, "^", 1, "^", 2'd1);
      step_cycle(1, "#", 0, 8'h00, 2'd1);
      check("r031_grant_req0_again", s_grant, 1);
      idle_cycles(3, 2'd1);

      // back-to-back record from req0, result latency from '#'
      send_str(0, "^1@000031fc: $28 <= 89abcdef#", 2'd2);
      lat = -1;
      for (int i = 1; i <= 5; i++) begin
         step_cycle(0, 8'h00, 0, 8'h00, 2'd2);
         if (s_rv == 1 && lat < 0) begin
            lat = i;
            check("r030_res_id", s_rid, 0);
            check("r030_res_type", s_rtype, 2);
         end
      end
      check("r030_latency", lat, 3);

      // junk before '^' is swallowed while idle
      send_str(1, "xy", 2'd3);
      check("r032_chk_idle", s_chk, 0);
      send_str(1, "^z#", 2'd3);
      idle_cycles(4, 2'd3);

      // stall timeout
      send_str(0, "^a", 2'd1);
      lat = -1; hit_type = -1; hit_grant = -1;
      for (int i = 1; i <= TO + 3; i++) begin
         step_cycle(0, 8'h00, 0, 8'h00, 2'd1);
         if (s_rv == 1 && lat < 0) begin
            lat = i; hit_type = s_rtype; hit_grant = s_grant;
         end
      end
      check("r033_abort_cycle", lat, TO + 1);
      check("r033_type", hit_type, 0);
      check("r033_grant", hit_grant, 0);

      // overlong record, then priority must favour req1
      step_cycle(1, "^", 0, 8'h00, 2'd2);
      for (int i = 0; i < ML - 1; i++) step_cycle(1, "a", 0, 8'h00, 2'd2);
      step_cycle(1, "^", 1, "^", 2'd2);
      check("r034_abort_valid", s_rv, 1);
      check("r034_abort_type", s_rtype, 0);
      check("r034_req0_held", s_rdy0, 0);
      step_cycle(0, 8'h00, 1, "#", 2'd2);
      check("r034_grant_req1", s_grant, 2);
      idle_cycles(4, 2'd2);

      // asynchronous reset mid-record
      send_str(0, "^b", 2'd3);
      req0_valid = 0; req0_char = 8'h00;
      #1;
      check("r035_pre_chk", int'(chk_char), int'(8'h62));
      reset = 1'b0;
      #1;
      check("r035_chk", int'(chk_char), 0);
      check("r035_grant", int'(grant), 0);
      check("r035_resv", int'(res_valid), 0);
      check("r035_ready0", int'(req0_ready), 1);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      idle_cycles(6, 2'd3);

      // randomized traffic, with periodic low-activity stretches to hit timeouts
      for (int i = 0; i < 4000; i++) begin
         int pv;
         bit v0, v1;
         pv = (((i / 200) % 4) == 3) ? 1 : 8;
         v0 = ($urandom_range(0, 9) < pv);
         v1 = ($urandom_range(0, 9) < pv);
         step_cycle(v0, rand_char(), v1, rand_char(), 2'($urandom_range(0, 3)));
      end
      idle_cycles(TO + 4, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/checker_stream_arbiter.md
CHECKER_STREAM_ARBITER -- requirements
Module: checker_stream_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: consecutive stall cycles tolerated mid-record.
REQ-002 SHALL have parameter MAX_LEN, default 48: maximum characters per record, '^' and '#' included.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a character.
REQ-006 SHALL have ports req0_char / req1_char  input  8  ASCII character.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  character accepted this cycle (valid&ready).
REQ-008 SHALL have port chk_char  output  8  registered character stream to the shared format checker.
REQ-009 SHALL have port fmt_type  input  2  checker format result, valid one cycle after '#' is presented on chk_char.
REQ-010 SHALL have port res_valid  output  1  one-cycle result pulse.
REQ-011 SHALL have port res_id  output  1  requester owning the result.
REQ-012 SHALL have port res_type  output  2  captured format (0 = invalid/aborted).
REQ-013 SHALL have port grant  output  2  one-hot current owner; 00 when idle.

Function
REQ-014 SHALL implement states IDLE, STREAM, FLUSH, CAPTURE.
REQ-015 IDLE: both ready=1; accepted non-'^' characters discarded; chk_char=8'h00.
REQ-016 IDLE: accepted '^' locks grant to that requester, forwards '^', -> STREAM.
REQ-017 IDLE, both presenting '^' same cycle: priority requester wins; loser ready=0, its '^' stays pending.
REQ-018 Priority pointer SHALL toggle to the non-owner after every reported result (normal or abort); reset value 0.
REQ-019 STREAM: only owner ready=1; every accepted character appears on chk_char exactly one cycle later.
REQ-020 STREAM, owner valid low: chk_char=8'h00 that cycle; stall counter increments; any accepted character clears it.
REQ-021 STREAM, accepted '#' -> FLUSH (ready=0 both, chk_char='#'); next -> CAPTURE (chk_char=00); at end of CAPTURE fmt_type latched to res_type, res_valid=1 next cycle, -> IDLE.
REQ-022 Abort: stall counter reaching TIMEOUT, or length counter reaching MAX_LEN without '#', SHALL force res_type=0, res_valid=1, res_id=owner next cycle, -> IDLE.
REQ-023 A second '^' from owner in STREAM SHALL be forwarded unchanged (checker resynchronises); length counter reset to 1.
REQ-024 Latency '#' accept -> res_valid SHALL be exactly 3 cycles.
REQ-025 grant SHALL be 00 in IDLE, owner one-hot otherwise, including FLUSH/CAPTURE.

Reset
REQ-026 Reset low SHALL immediately clear: state=IDLE, chk_char=00, res_valid=0, res_id=0, res_type=0, grant=00, priority=0, both counters=0.
REQ-027 Reset asserted mid-record SHALL discard the record with no res_valid pulse; ready outputs follow IDLE rules after release.

Structure
REQ-028 Shared package checker_pkg SHALL hold state enum, CH_START='^', CH_END='#', CH_NUL=8'h00, fmt code constants.
REQ-029 Stall/length counting SHALL be a sub-module stream_watchdog (inputs tick/clear, output expired).

Verification
REQ-030 req0 sends "^1@000031fc: $28 <= 89abcdef#" back-to-back -> chk_char mirrors it 1 cycle late; res_valid 3 cycles after '#', res_id=0, res_type=fmt_type.
REQ-031 Both assert '^' same cycle after reset -> req0 granted, req1 ready=0 until req0 result; req1 then granted; next simultaneous '^' grants req0 again.
REQ-032 req1 sends "xy" then "^..." in IDLE -> 'x','y' consumed, chk_char stays 00 until '^'.
REQ-033 Owner stalls 16 cycles mid-record -> res_valid, res_type=0, grant=00 the following cycle.
REQ-034 Owner sends 48 characters without '#' -> abort, res_type=0, priority toggled.
REQ-035 Reset pulsed low while STREAM -> outputs zero asynchronously, no res_valid afterwards.
